// File: rtl/io_cycle_master.sv
// Bus initiator for the 8-bit I/O port space: runs one command as a timed
// setup / strobe / hold cycle and returns read data or a timeout status.
module io_cycle_master #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic [7:0] io_address,
    output logic       io_iowrite,
    output logic       io_ioread,
    output logic [7:0] io_dout,
    output logic       io_dout_en,
    input  logic [7:0] io_din,
    input  logic       io_wait_n,
    output logic       busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StStrobe = 3'd2;
    localparam logic [2:0] StHold   = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;

    localparam int unsigned MaxSh    = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MaxPhase = (MaxSh > STROBE_CYC) ? MaxSh : STROBE_CYC;
    localparam int unsigned CntW     = $clog2(MaxPhase + 1);

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            write_q, write_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        write_d   = write_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StSetup;
                    cnt_d   = CntW'(SETUP_CYC);
                    tmo_d   = 8'h00;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    if (cmd_write) dout_d = cmd_wdata;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StStrobe;
                    cnt_d   = CntW'(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                // Wait is only honoured on the last counted clock and beyond.
                if (cnt_q > CntW'(1)) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (io_wait_n) begin
                    state_d   = StHold;
                    cnt_d     = CntW'(HOLD_CYC);
                    rdata_d   = write_q ? 8'h00 : io_din;
                    timeout_d = 1'b0;
                end else if (tmo_q == 8'(TIMEOUT_CYC)) begin
                    state_d   = StHold;
                    cnt_d     = CntW'(HOLD_CYC);
                    rdata_d   = write_q ? 8'h00 : 8'hFF;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'h01;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tmo_q     <= 8'h00;
            write_q   <= 1'b0;
            addr_q    <= 8'h00;
            dout_q    <= 8'h00;
            rdata_q   <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        cmd_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        rsp_valid   = (state_q == StResp);
        rsp_rdata   = rdata_q;
        rsp_timeout = timeout_q;
        io_address  = addr_q;
        io_dout     = dout_q;
        io_iowrite  = (state_q == StStrobe) && write_q;
        io_ioread   = (state_q == StStrobe) && !write_q;
        io_dout_en  = write_q && ((state_q == StSetup) || (state_q == StStrobe) ||
                                  (state_q == StHold));
    end

endmodule

// File: tb/tb_io_cycle_master.sv
// Directed bench for io_cycle_master (TIMEOUT_CYC = 8, other timing at defaults).
module tb_io_cycle_master;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic [7:0] io_address;
    logic       io_iowrite;
    logic       io_ioread;
    logic [7:0] io_dout;
    logic       io_dout_en;
    logic [7:0] io_din;
    logic       io_wait_n;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    io_cycle_master #(
        .SETUP_CYC  (1),
        .STROBE_CYC (2),
        .HOLD_CYC   (1),
        .TIMEOUT_CYC(8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .io_address (io_address),
        .io_iowrite (io_iowrite),
        .io_ioread  (io_ioread),
        .io_dout    (io_dout),
        .io_dout_en (io_dout_en),
        .io_din     (io_din),
        .io_wait_n  (io_wait_n),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one command; clock k counts from the accept edge (k = 1 is SETUP).
    // Wait is held low on clocks [wstart, wstart+wlen); io_din switches to din1 on release.
    task automatic do_cycle(input string name, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] din0,
                            input logic [7:0] din1, input int wstart, input int wlen,
                            input int strb, input int resp, input logic [7:0] exp_rd,
                            input logic exp_to);
        logic stb;
        logic oth;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        io_din    = din0;
        io_wait_n = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        for (int k = 1; k <= resp + 1; k++) begin
            stb = wr ? io_iowrite : io_ioread;
            oth = wr ? io_ioread : io_iowrite;
            check_eq({name, "/strobe"}, stb, (k >= 2 && k <= strb + 1));
            check_eq({name, "/other_strobe"}, oth, 1'b0);
            check_eq({name, "/dout_en"}, io_dout_en, (wr && k <= resp - 1));
            check_eq({name, "/rsp_valid"}, rsp_valid, (k == resp));
            check_eq({name, "/busy"}, busy, (k <= resp));
            check_eq({name, "/address"}, io_address, addr);
            if (wr && k < resp) check_eq({name, "/dout"}, io_dout, wdata);
            if (k == resp) begin
                check_eq({name, "/rdata"}, rsp_rdata, exp_rd);
                check_eq({name, "/timeout"}, rsp_timeout, exp_to);
            end
            if (k <= resp) begin
                io_wait_n = !(k >= wstart && k < wstart + wlen);
                io_din    = (wlen > 0 && k >= wstart + wlen) ? din1 : din0;
                step();
            end
        end
        check_eq({name, "/ready_after"}, cmd_ready, 1'b1);
        io_wait_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        io_din    = 8'h00;
        io_wait_n = 1'b1;
        #22;
        check_eq("rst/address", io_address, 8'h00);
        check_eq("rst/dout", io_dout, 8'h00);
        check_eq("rst/rdata", rsp_rdata, 8'h00);
        check_eq("rst/strobes", {io_iowrite, io_ioread, io_dout_en}, 3'b000);
        check_eq("rst/rsp", {rsp_valid, rsp_timeout, busy}, 3'b000);
        reset_n = 1'b1;
        step();
        check_eq("rst/ready", cmd_ready, 1'b1);

        do_cycle("wr6c", 1'b1, 8'h6C, 8'hA5, 8'h00, 8'h00, 0, 0, 2, 5, 8'h00, 1'b0);
        do_cycle("rd35", 1'b0, 8'h35, 8'h00, 8'h3C, 8'h3C, 0, 0, 2, 5, 8'h3C, 1'b0);
        do_cycle("rdwait", 1'b0, 8'h68, 8'h00, 8'h00, 8'h5A, 3, 3, 5, 8, 8'h5A, 1'b0);
        do_cycle("tmo", 1'b0, 8'h02, 8'h00, 8'hC3, 8'hC3, 3, 200, 10, 13, 8'hFF, 1'b1);
        do_cycle("after_tmo", 1'b1, 8'h40, 8'h9D, 8'h00, 8'h00, 0, 0, 2, 5, 8'h00, 1'b0);

        // Two commands back-to-back with cmd_valid held high.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_wdata = 8'h11;
        io_din    = 8'h77;
        step();
        for (int k = 1; k <= 12; k++) begin
            check_eq("q/ready", cmd_ready, (k == 6 || k == 12));
            check_eq("q/iowrite", io_iowrite, (k == 2 || k == 3));
            check_eq("q/ioread", io_ioread, (k == 8 || k == 9));
            check_eq("q/overlap", io_iowrite & io_ioread, 1'b0);
            check_eq("q/rsp_valid", rsp_valid, (k == 5 || k == 11));
            if (k == 2) check_eq("q/addr1", io_address, 8'hFF);
            if (k == 7) check_eq("q/addr2", io_address, 8'h06);
            if (k == 11) check_eq("q/rdata2", rsp_rdata, 8'h77);
            if (k == 1) begin
                cmd_write = 1'b0;
                cmd_addr  = 8'h06;
                cmd_wdata = 8'h00;
            end
            if (k == 7) cmd_valid = 1'b0;
            step();
        end

        // Reset pulse while the OUT strobe is high.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h09;
        cmd_wdata = 8'h3E;
        step();
        cmd_valid = 1'b0;
        step();
        check_eq("rstmid/strobe_on", io_iowrite, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid/iowrite", io_iowrite, 1'b0);
        check_eq("rstmid/address", io_address, 8'h00);
        check_eq("rstmid/dout", io_dout, 8'h00);
        check_eq("rstmid/rdata", rsp_rdata, 8'h00);
        check_eq("rstmid/flags", {io_ioread, io_dout_en, rsp_valid, rsp_timeout, busy}, 5'b0);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("rstmid/no_rsp", rsp_valid, 1'b0);
            check_eq("rstmid/ready", cmd_ready, 1'b1);
            check_eq("rstmid/busy", busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
